// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction SRAM
// and pushes {address, instruction} into the downstream FIFO without overfilling it.
module fetch_unit #(
  parameter int I_WIDTH  = 12,
  parameter int A_WIDTH  = 8,
  parameter int LG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [A_WIDTH-1:0] start_addr_i,
  input  logic               halt_i,
  input  logic               redirect_i,
  input  logic [A_WIDTH-1:0] redirect_addr_i,
  output logic               mem_rd_en_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  input  logic [I_WIDTH-1:0] mem_data_i,
  output logic               fifo_enque_o,
  output logic [A_WIDTH-1:0] fifo_addr_o,
  output logic [I_WIDTH-1:0] fifo_data_o,
  output logic               fifo_clear_o,
  input  logic               fifo_deque_i,
  output logic               busy_o,
  output logic               dbg_state_o
);

  localparam int CW = LG_DEPTH + 1;
  localparam logic [CW-1:0] CAP = CW'((1 << LG_DEPTH) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  logic [A_WIDTH-1:0] pc_r;
  logic               inflight_r;
  logic [A_WIDTH-1:0] inflight_addr_r;
  logic [CW-1:0]      cnt_r;

  logic [CW-1:0]      fifo_cnt;
  logic [CW-1:0]      cnt_after_deq;
  logic               deq_eff;
  logic               issue;

  // Handshake: fifo_enque_o is a valid-only push with no ready; the credit
  // counter (FIFO entries + in-flight read) guarantees space for every push,
  // and a dequeue strobe only returns credit when the FIFO actually holds data.
  always_comb begin
    fifo_cnt      = cnt_r - CW'(inflight_r);
    deq_eff       = fifo_deque_i & (fifo_cnt != '0);
    cnt_after_deq = cnt_r - CW'(deq_eff);
    issue         = (state_r == RUN) & ~halt_i & ~redirect_i & (cnt_after_deq < CAP);
  end

  assign mem_rd_en_o  = issue;
  assign mem_addr_o   = pc_r;
  assign fifo_enque_o = inflight_r & ~redirect_i;
  assign fifo_addr_o  = inflight_addr_r;
  assign fifo_data_o  = mem_data_i;
  assign fifo_clear_o = redirect_i;
  assign busy_o       = (state_r == RUN) | inflight_r;
  assign dbg_state_o  = state_r;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r         <= IDLE;
      pc_r            <= '0;
      inflight_r      <= 1'b0;
      inflight_addr_r <= '0;
      cnt_r           <= '0;
    end else if (redirect_i) begin
      // Redirect squashes the returning read and empties the FIFO; state holds.
      pc_r       <= redirect_addr_i;
      cnt_r      <= '0;
      inflight_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (start_i) begin
          state_r <= RUN;
          pc_r    <= start_addr_i;
        end
        RUN: if (halt_i) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      if (issue) begin
        pc_r            <= pc_r + 1'b1;
        inflight_addr_r <= pc_r;
      end
      inflight_r <= issue;
      cnt_r      <= cnt_after_deq + CW'(issue);
    end
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n_i) cnt_r <= CAP);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// against a queue-based model of the downstream FIFO and the fetch PC.
module tb_fetch_unit;
  localparam int IW  = 12;
  localparam int AW  = 8;
  localparam int CAP = 3;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic          halt_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_addr_i = '0;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_data_i = '0;
  logic          fifo_enque_o;
  logic [AW-1:0] fifo_addr_o;
  logic [IW-1:0] fifo_data_o;
  logic          fifo_clear_o;
  logic          fifo_deque_i = 1'b0;
  logic          busy_o;
  logic          dbg_state_o;

  fetch_unit #(.I_WIDTH(IW), .A_WIDTH(AW), .LG_DEPTH(2)) dut (
    .clk(clk), .rst_n_i(rst_n_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .halt_i(halt_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .fifo_enque_o(fifo_enque_o), .fifo_addr_o(fifo_addr_o), .fifo_data_o(fifo_data_o),
    .fifo_clear_o(fifo_clear_o), .fifo_deque_i(fifo_deque_i), .busy_o(busy_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- instruction SRAM model ----------------
  logic [IW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);

  always @(posedge clk) begin
    if (mem_rd_en_o) mem_data_i <= mem[mem_addr_o];
    else             mem_data_i <= IW'($urandom);
  end

  // ---------------- scoreboard / reference model ----------------
  logic [AW-1:0] exp_q[$];      // addresses currently held by the downstream FIFO
  bit            m_run;
  logic [AW-1:0] m_pc;
  bit            m_pend;
  logic [AW-1:0] m_pend_addr;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_reads  = 0;
  int            n_enqs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run = 0; m_pc = '0; m_pend = 0; m_pend_addr = '0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic cycle(input bit st, input logic [AW-1:0] sa, input bit hl,
                       input bit rd, input logic [AW-1:0] ra, input bit dq);
    bit deq_ok, e_issue, e_enq;
    int occupancy;
    @(negedge clk);
    start_i = st; start_addr_i = sa; halt_i = hl;
    redirect_i = rd; redirect_addr_i = ra; fifo_deque_i = dq;
    #1;
    deq_ok    = dq && (exp_q.size() != 0);
    occupancy = exp_q.size() + int'(m_pend) - int'(deq_ok);
    e_issue   = m_run && !hl && !rd && (occupancy < CAP);
    e_enq     = m_pend && !rd;
    check("mem_rd_en", mem_rd_en_o, e_issue);
    check("mem_addr", mem_addr_o, m_pc);
    check("fifo_enque", fifo_enque_o, e_enq);
    check("fifo_addr", fifo_addr_o, m_pend_addr);
    if (e_enq) check("fifo_data", fifo_data_o, mem[m_pend_addr]);
    check("fifo_clear", fifo_clear_o, rd);
    check("busy", busy_o, m_run || m_pend);
    check("state", dbg_state_o, m_run);
    if (mem_rd_en_o) n_reads++;
    if (fifo_enque_o) n_enqs++;
    if (rd) begin
      exp_q.delete();
      m_pend = 0;
      m_pc   = ra;
    end else begin
      if (deq_ok) void'(exp_q.pop_front());
      if (e_enq) exp_q.push_back(m_pend_addr);
      m_pend = e_issue;
      if (e_issue) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 1'b1;
      end
      if (!m_run && st) begin
        m_run = 1;
        m_pc  = sa;
      end else if (m_run && hl) begin
        m_run = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit dq);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, dq);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_i = 0; halt_i = 0; redirect_i = 0; fifo_deque_i = 0;
    rst_n_i = 1'b0;
    #1;
    check("rst_rd_en", mem_rd_en_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, '0);
    check("rst_enque", fifo_enque_o, 1'b0);
    check("rst_fifo_addr", fifo_addr_o, '0);
    check("rst_clear", fifo_clear_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_state", dbg_state_o, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, e0;
    model_reset();
    do_reset();

    // Streaming from 0x10 with a free-running consumer.
    cycle(1, 8'h10, 0, 0, '0, 1);
    r0 = n_reads;
    idle(8, 1);
    check("stream_reads", n_reads - r0, 8);

    // Credit stall: no dequeues, exactly three reads, then one dequeue frees one.
    do_reset();
    cycle(1, 8'h20, 0, 0, '0, 0);
    r0 = n_reads; e0 = n_enqs;
    idle(6, 0);
    check("stall_reads", n_reads - r0, 3);
    check("stall_enqs", n_enqs - e0, 3);
    r0 = n_reads;
    cycle(0, '0, 0, 0, '0, 1);
    check("credit_read_addr", mem_addr_o, 8'h23);
    check("credit_read_en", mem_rd_en_o, 1'b1);
    idle(3, 0);
    check("credit_reads", n_reads - r0, 1);

    // Redirect one cycle after the read of 0x05 issues.
    do_reset();
    cycle(1, 8'h03, 0, 0, '0, 1);
    idle(3, 1);
    cycle(0, '0, 0, 1, 8'h80, 1);
    idle(3, 1);

    // PC wrap at the top of the address space.
    do_reset();
    cycle(1, 8'hFE, 0, 0, '0, 1);
    r0 = n_reads;
    idle(5, 1);
    check("wrap_reads", n_reads - r0, 5);

    // Halt after the read of 0x31, then restart at 0x40.
    do_reset();
    cycle(1, 8'h30, 0, 0, '0, 1);
    idle(2, 1);
    cycle(0, '0, 1, 0, '0, 1);
    idle(2, 1);
    cycle(1, 8'h40, 1, 0, '0, 1);
    idle(4, 1);

    // Reset with a read in flight.
    do_reset();
    cycle(1, 8'h50, 0, 0, '0, 1);
    idle(2, 1);
    do_reset();
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, AW'($urandom),
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 19) == 0, AW'($urandom),
            $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction FIFO in the 12-bit processor.
- Holds the PC and issues reads to a synchronous instruction SRAM with 1-cycle read latency.
- Enqueues each returned {address, instruction} pair into the FIFO.
- Tracks FIFO occupancy plus in-flight reads with a credit counter, so it never overfills the FIFO. Supports start, halt and branch redirect; redirect flushes the FIFO.

Parameters:
- I_WIDTH, 12, instruction width.
- A_WIDTH, 8, instruction SRAM address width; PC width.
- LG_DEPTH, 2, lg2 of downstream FIFO entries; usable capacity CAP = 2**LG_DEPTH - 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  begin fetching at start_addr_i; honoured only in IDLE.
- start_addr_i  input  A_WIDTH  initial PC.
- halt_i  input  1  stop issuing; return to IDLE.
- redirect_i  input  1  branch/flush request.
- redirect_addr_i  input  A_WIDTH  new PC on redirect.
- mem_rd_en_o  output  1  SRAM read enable.
- mem_addr_o  output  A_WIDTH  SRAM read address (current PC).
- mem_data_i  input  I_WIDTH  SRAM read data, valid the cycle after mem_rd_en_o.
- fifo_enque_o  output  1  enqueue to FIFO.
- fifo_addr_o  output  A_WIDTH  address of the enqueued instruction.
- fifo_data_o  output  I_WIDTH  enqueued instruction (mem_data_i pass-through).
- fifo_clear_o  output  1  FIFO clear.
- fifo_deque_i  input  1  consumer dequeue strobe, observed for credit return.
- busy_o  output  1  high in RUN or while a read is in flight.

Behaviour:
- State machine:
  - IDLE: reset state.
  - IDLE -> RUN on start_i; PC <= start_addr_i.
  - RUN -> IDLE on halt_i. halt_i in IDLE has no effect.
- Registers:
  - pc_r (A_WIDTH).
  - inflight_r (1 bit) and inflight_addr_r (A_WIDTH).
  - cnt_r (LG_DEPTH+1 bits) = entries in FIFO + in-flight reads.
- Reset (async, rst_n_i=0): state=IDLE, pc_r=0, inflight_r=0, cnt_r=0.
  - mem_rd_en_o=0, fifo_enque_o=0, fifo_clear_o=0, busy_o=0.
  - mem_addr_o=0, fifo_addr_o=0.
- Credit return: fifo_cnt = cnt_r - inflight_r; deq_eff = fifo_deque_i & (fifo_cnt != 0). A dequeue of an empty FIFO is ignored.
- Issue (combinational):
  - issue = (state==RUN) & !halt_i & !redirect_i & ((cnt_r - deq_eff) < CAP).
  - mem_rd_en_o = issue; mem_addr_o = pc_r.
- On issue:
  - pc_r <= pc_r + 1, wrapping modulo 2**A_WIDTH (0xFF -> 0x00).
  - inflight_r <= 1; inflight_addr_r <= pc_r.
  - Without issue: inflight_r <= 0.
- Enqueue:
  - fifo_enque_o = inflight_r & !redirect_i.
  - fifo_addr_o = inflight_addr_r; fifo_data_o = mem_data_i.
- Counter: cnt_r <= cnt_r + issue - deq_eff. It never exceeds CAP, so the FIFO is never written when full.
- Throughput: sustains 1 instruction/cycle when the consumer dequeues every cycle.
- Latency: PC presented at cycle t -> FIFO enqueue at cycle t+1.
- Redirect (any state, highest priority over start/halt):
  - fifo_clear_o = redirect_i, combinationally, same cycle.
  - pc_r <= redirect_addr_i; cnt_r <= 0; inflight_r <= 0.
  - The read returning this cycle is squashed (no enqueue). No issue this cycle.
  - fifo_deque_i this cycle is ignored.
  - State is unchanged: RUN resumes fetch from the new PC next cycle; IDLE stays IDLE.
- Halt:
  - No issue in the halt cycle.
  - A read already in flight still enqueues the next cycle.
  - cnt_r keeps tracking dequeues while IDLE.
- start_i and halt_i together in IDLE: start wins; halt is ignored because it only acts in RUN.
- Reset mid-operation: everything returns to reset values immediately; the in-flight read is dropped.
- busy_o = (state==RUN) | inflight_r.

Test Plan:
- Reset, start_i with start_addr_i=0x10, consumer dequeues every cycle -> mem_addr_o 0x10,0x11,0x12… on consecutive cycles; fifo_addr_o 0x10,0x11… one cycle later; fifo_data_o equals the SRAM contents at each address.
- Start at 0x20, no dequeue -> exactly 3 reads issued (0x20–0x22), 3 enqueues, then mem_rd_en_o stays 0; one dequeue -> exactly one more read, at 0x23.
- Redirect to 0x80 one cycle after the read of 0x05 issues -> fifo_clear_o=1 that cycle, no enqueue of 0x05, cnt_r=0; next cycle mem_addr_o=0x80.
- Start at 0xFE with free dequeue -> addresses 0xFE, 0xFF, 0x00, 0x01; no stall at the wrap.
- halt_i asserted the cycle after the read of 0x31 issues -> 0x31 still enqueued, no further reads, busy_o falls one cycle later; start_i at 0x40 restarts there.
- Assert rst_n_i low mid-stream with a read in flight -> all outputs 0 immediately, no enqueue after release, state IDLE until start_i.
